alu_mul_seq: RTL and testbench

- Multi-cycle unsigned 16x16 -> 32 shift-and-add multiplier sequencer.
- Owns no arithmetic of its own; drives the shared 16-bit ALU's control/operand inputs each cycle and captures its result and flags.
- Sits beside the execute stage; the ALU mux selects this block's drive while o_busy is high.

---
 rtl/alu_mul_seq_pkg.sv | 26 ++
 rtl/alu_mul_seq_if.sv | 43 ++++
 rtl/alu_mul_seq.sv | 159 +++++++++++++++
 tb/tb_alu_mul_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_seq_pkg.sv
// alu_pkg: types and constants shared by the shift-and-add multiplier
// sequencer and the ALU it drives.
//   ALU_PASS / ALU_ADD / ALU_SHR : ALU control codes issued by the sequencer
//   FLAG_C/S/V/Z                 : bit positions inside a {c,s,v,z} flag word
//   mul_state_t                  : sequencer state encoding
package alu_pkg;

   localparam int unsigned FLAG_W = 4;

   localparam logic [5:0] ALU_PASS = 6'h00;
   localparam logic [5:0] ALU_ADD  = 6'h0A;
   localparam logic [5:0] ALU_SHR  = 6'h30;

   localparam int unsigned FLAG_C = 3;
   localparam int unsigned FLAG_S = 2;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_Z = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: bundles the multiplier request/result handshake and the
// drive/return lines of the shared ALU.
//   slave  : the sequencer (accepts requests, drives the ALU)
//   master : the requester plus the external combinational ALU
// Signals: i_start/o_ready accept handshake, i_a/i_b operands,
//   o_valid/i_res_ready result handshake, o_product/o_flag result,
//   o_busy ALU ownership, o_alu_* ALU inputs, i_alu_* ALU outputs.
interface alu_mul_seq_if
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CTRL_W = 6
);

   logic                  i_start;
   logic [DATA_W-1:0]     i_a;
   logic [DATA_W-1:0]     i_b;
   logic                  o_ready;
   logic                  o_busy;
   logic                  o_valid;
   logic                  i_res_ready;
   logic [2*DATA_W-1:0]   o_product;
   logic [FLAG_W-1:0]     o_flag;
   logic [CTRL_W-1:0]     o_alu_ctrl;
   logic [DATA_W-1:0]     o_alu_a;
   logic [DATA_W-1:0]     o_alu_b;
   logic                  o_alu_carry;
   logic [DATA_W-1:0]     i_alu_data;
   logic [FLAG_W-1:0]     i_alu_flag;

   modport slave (
      input  i_start, i_a, i_b, i_res_ready, i_alu_data, i_alu_flag,
      output o_ready, o_busy, o_valid, o_product, o_flag,
             o_alu_ctrl, o_alu_a, o_alu_b, o_alu_carry
   );

   modport master (
      output i_start, i_a, i_b, i_res_ready, i_alu_data, i_alu_flag,
      input  o_ready, o_busy, o_valid, o_product, o_flag,
             o_alu_ctrl, o_alu_a, o_alu_b, o_alu_carry
   );

endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned DATA_W x DATA_W -> 2*DATA_W shift-and-add multiplier
// that borrows the shared combinational ALU for every add and shift.
// Ports:
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   bus     : alu_mul_seq_if.slave (request/result handshake + ALU drive)
// Optional build macro ALU_MUL_ZERO_SKIP_EN: iterations whose multiplier bit
// is zero skip the ADD step, giving 16 + popcount(i_b) cycle latency.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CTRL_W = 6
)(
   input  logic           i_clk,
   input  logic           i_rst_n,
   alu_mul_seq_if.slave   bus
);

   mul_state_t            state;
   mul_state_t            state_nxt;

   logic [DATA_W-1:0]     acc;
   logic [DATA_W-1:0]     lo;
   logic [DATA_W-1:0]     mcand;
   logic                  c_sav;
   logic [4:0]            cnt;
   logic [FLAG_W-1:0]     flag_q;

   logic                  last_iter;
   logic [DATA_W-1:0]     acc_shr;
   logic [DATA_W-1:0]     lo_shr;
   logic [2*DATA_W-1:0]   prod_nxt;
   logic                  unused_alu_flags;

   assign last_iter = (cnt == 5'd15);

   // The ALU shifts acc right; its top bit is replaced by the saved add
   // carry so the 17th bit of each partial sum is never lost.
   assign acc_shr  = {c_sav, bus.i_alu_data[DATA_W-2:0]};
   assign lo_shr   = {acc[0], lo[DATA_W-1:1]};
   assign prod_nxt = {acc_shr, lo_shr};

   assign unused_alu_flags = ^bus.i_alu_flag[FLAG_S:FLAG_Z];

   // state register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.i_start) begin
`ifdef ALU_MUL_ZERO_SKIP_EN
               state_nxt = bus.i_b[0] ? ADD : SHIFT;
`else
               state_nxt = ADD;
`endif
            end
         end
         ADD:   state_nxt = SHIFT;
         SHIFT: begin
            if (last_iter) begin
               state_nxt = DONE;
            end else begin
`ifdef ALU_MUL_ZERO_SKIP_EN
               // lo[1] becomes the multiplier bit of the next iteration
               state_nxt = lo[1] ? ADD : SHIFT;
`else
               state_nxt = ADD;
`endif
            end
         end
         DONE: begin
            if (bus.i_res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // datapath registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         acc    <= '0;
         lo     <= '0;
         mcand  <= '0;
         c_sav  <= 1'b0;
         cnt    <= '0;
         flag_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  mcand <= bus.i_a;
                  lo    <= bus.i_b;
                  acc   <= '0;
                  cnt   <= '0;
                  c_sav <= 1'b0;
               end
            end
            ADD: begin
               acc   <= bus.i_alu_data;
               c_sav <= bus.i_alu_flag[FLAG_C];
            end
            SHIFT: begin
               acc   <= acc_shr;
               lo    <= lo_shr;
               cnt   <= cnt + 5'd1;
               // cleared so a skipped ADD leaves no stale carry behind
               c_sav <= 1'b0;
               if (last_iter) begin
                  flag_q <= {1'b0, prod_nxt[2*DATA_W-1], |acc_shr, ~|prod_nxt};
               end
            end
            default: ;
         endcase
      end
   end

   // outputs
   always_comb begin
      bus.o_ready    = 1'b0;
      bus.o_busy     = 1'b0;
      bus.o_valid    = 1'b0;
      bus.o_alu_ctrl = CTRL_W'(ALU_PASS);
      bus.o_alu_a    = '0;
      bus.o_alu_b    = '0;
      case (state)
         IDLE: bus.o_ready = 1'b1;
         ADD: begin
            bus.o_busy     = 1'b1;
            bus.o_alu_ctrl = CTRL_W'(ALU_ADD);
            bus.o_alu_a    = acc;
            bus.o_alu_b    = lo[0] ? mcand : '0;
         end
         SHIFT: begin
            bus.o_busy     = 1'b1;
            bus.o_alu_ctrl = CTRL_W'(ALU_SHR);
            bus.o_alu_a    = acc;
         end
         DONE: bus.o_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.o_alu_carry = 1'b0;
   assign bus.o_product   = {acc, lo};
   assign bus.o_flag      = flag_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed bench for alu_mul_seq with a behavioural model of
// the shared ALU (pass / add / logical shift right) on the interface.
// Honours ALU_MUL_ZERO_SKIP_EN for expected latencies and drive sequences.
module tb_alu_mul_seq;

`ifdef ALU_MUL_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   alu_mul_seq_if #(.DATA_W(16), .CTRL_W(6)) bus ();

   alu_mul_seq #(.DATA_W(16), .CTRL_W(6)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // combinational ALU model
   logic [16:0] alu_sum;
   always_comb begin
      alu_sum = {1'b0, bus.o_alu_a} + {1'b0, bus.o_alu_b} + {16'd0, bus.o_alu_carry};
      bus.i_alu_data = bus.o_alu_a;
      bus.i_alu_flag = 4'b0000;
      case (bus.o_alu_ctrl)
         6'h0A: begin
            bus.i_alu_data = alu_sum[15:0];
            bus.i_alu_flag = {alu_sum[16], alu_sum[15],
                              (bus.o_alu_a[15] == bus.o_alu_b[15]) && (alu_sum[15] != bus.o_alu_a[15]),
                              alu_sum[15:0] == 16'd0};
         end
         6'h30: begin
            bus.i_alu_data = {1'b0, bus.o_alu_a[15:1]};
            bus.i_alu_flag = {bus.o_alu_a[0], 1'b0, 1'b0, bus.o_alu_a[15:1] == 15'd0};
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.i_a     = a;
      bus.i_b     = b;
      bus.i_start = 1'b1;
      @(posedge clk);
      #1 bus.i_start = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.o_valid && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      bus.i_res_ready = 1'b1;
      @(posedge clk);
      #1 bus.i_res_ready = 1'b0;
      check({tag, "_ready_after"}, {31'd0, bus.o_ready}, 32'd1);
      check({tag, "_valid_after"}, {31'd0, bus.o_valid}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input logic [31:0] exp_p, input logic [3:0] exp_f);
      int lat;
      start_op(a, b);
      wait_valid(lat);
      check({tag, "_lat"},     lat,                    exp_lat);
      check({tag, "_product"}, bus.o_product,          exp_p);
      check({tag, "_flag"},    {28'd0, bus.o_flag},    {28'd0, exp_f});
      check({tag, "_busy"},    {31'd0, bus.o_busy},    32'd0);
      consume(tag);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      int  lat;
      bit  saw_valid;
      logic [15:0] da;
      logic [15:0] db;
      checks          = 0;
      failures        = 0;
      rst_n           = 1'b0;
      bus.i_start     = 1'b0;
      bus.i_a         = '0;
      bus.i_b         = '0;
      bus.i_res_ready = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready",   {31'd0, bus.o_ready},     32'd1);
      check("rst_busy",    {31'd0, bus.o_busy},      32'd0);
      check("rst_valid",   {31'd0, bus.o_valid},     32'd0);
      check("rst_product", bus.o_product,            32'd0);
      check("rst_flag",    {28'd0, bus.o_flag},      32'd0);
      check("rst_ctrl",    {26'd0, bus.o_alu_ctrl},  32'h00);
      check("rst_alu_a",   {16'd0, bus.o_alu_a},     32'd0);
      check("rst_alu_b",   {16'd0, bus.o_alu_b},     32'd0);
      check("rst_carry",   {31'd0, bus.o_alu_carry}, 32'd0);
      rst_n = 1'b1;

      // main vectors: 3*5, all-ones, zero multiplier, overflow into hi
      run_op("m3x5",   16'h0003, 16'h0005, SKIP ? 18 : 32, 32'h0000000F, 4'b0000);
      run_op("mffff",  16'hFFFF, 16'hFFFF, 32,             32'hFFFE0001, 4'b0110);
      run_op("mzero",  16'h1234, 16'h0000, SKIP ? 16 : 32, 32'h00000000, 4'b0001);
      run_op("m8000",  16'h8000, 16'h0002, SKIP ? 17 : 32, 32'h00010000, 4'b0010);

      // per-cycle ALU drive for 0x00A5 * 0x0005
      da = 16'h00A5;
      db = 16'h0005;
      start_op(da, db);
      check("drv_first_a",     {16'd0, bus.o_alu_a},     32'd0);
      check("drv_first_carry", {31'd0, bus.o_alu_carry}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         if (db[i] || !SKIP) begin
            check($sformatf("drv_add_ctrl%0d", i), {26'd0, bus.o_alu_ctrl}, 32'h0A);
            check($sformatf("drv_add_b%0d", i),    {16'd0, bus.o_alu_b},    db[i] ? {16'd0, da} : 32'd0);
            @(posedge clk);
            #1;
         end
         check($sformatf("drv_shr_ctrl%0d", i), {26'd0, bus.o_alu_ctrl}, 32'h30);
         check($sformatf("drv_shr_b%0d", i),    {16'd0, bus.o_alu_b},    32'd0);
         check($sformatf("drv_shr_busy%0d", i), {31'd0, bus.o_busy},     32'd1);
         @(posedge clk);
         #1;
      end
      check("drv_valid",   {31'd0, bus.o_valid}, 32'd1);
      check("drv_product", bus.o_product,        32'h00000339);
      consume("drv");

      // start during busy is ignored; result held while consumer stalls
      start_op(16'h0007, 16'h0009);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("bsy_ready", {31'd0, bus.o_ready}, 32'd0);
      bus.i_a     = 16'h0001;
      bus.i_b     = 16'h0001;
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      wait_valid(lat);
      check("bsy_got_valid", {31'd0, bus.o_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("hold_valid%0d", i),   {31'd0, bus.o_valid}, 32'd1);
         check($sformatf("hold_product%0d", i), bus.o_product,        32'h0000003F);
         check($sformatf("hold_ready%0d", i),   {31'd0, bus.o_ready}, 32'd0);
      end
      // consume and start together: start must not be taken
      @(negedge clk);
      bus.i_res_ready = 1'b1;
      bus.i_start     = 1'b1;
      bus.i_a         = 16'h0002;
      bus.i_b         = 16'h0002;
      @(posedge clk);
      #1;
      bus.i_res_ready = 1'b0;
      bus.i_start     = 1'b0;
      check("sim_ready", {31'd0, bus.o_ready}, 32'd1);
      check("sim_valid", {31'd0, bus.o_valid}, 32'd0);
      @(negedge clk);
      check("sim_not_started", {31'd0, bus.o_busy}, 32'd0);

      // reset mid-operation
      start_op(16'h1111, 16'h0F0F);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("mrst_ready",   {31'd0, bus.o_ready},    32'd1);
      check("mrst_busy",    {31'd0, bus.o_busy},     32'd0);
      check("mrst_ctrl",    {26'd0, bus.o_alu_ctrl}, 32'h00);
      check("mrst_product", bus.o_product,           32'd0);
      check("mrst_flag",    {28'd0, bus.o_flag},     32'd0);
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.o_valid) saw_valid = 1'b1;
      end
      check("mrst_no_valid", {31'd0, saw_valid}, 32'd0);

      // sequencer still usable after the abort
      run_op("post", 16'h0100, 16'h0100, SKIP ? 17 : 32, 32'h00010000, 4'b0010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
